// File: rtl/tbus_master_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tbus_master_port                                             |
// | Description : Requester-side bus port. Queues single-beat commands, runs   |
// |               the req/gnt/sel handshake, issues one beat, returns the      |
// |               response (or a timeout error) and pulses finish.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tbus_master_port #(
  parameter int ADR_W  = 32,
  parameter int DEPTH  = 2,
  parameter int TO_CYC = 255,
  parameter int TO_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [31:0]      cmd_wdata,
  input  logic [3:0]       cmd_wstrb,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             req,
  input  logic             gnt,
  input  logic             sel,
  output logic             finish,
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic             bus_we,
  output logic [ADR_W-1:0] bus_adr,
  output logic [31:0]      bus_wdata,
  output logic [3:0]       bus_wstrb,
  input  logic             bus_rvalid,
  input  logic [31:0]      bus_rdata
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = 1 + ADR_W + 32 + 4;

  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ADDR = 3'd2,
    S_RESP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              timed_out;
  logic [31:0]       capture_data;
  logic [ENT_W-1:0]  head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  // The DONE pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign cmd_ready  = !fifo_full || (state_q == S_DONE);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == S_DONE);

  assign head = mem_q[rd_ptr_q];
  assign {bus_we, bus_adr, bus_wdata, bus_wstrb} = head;

  assign timed_out    = (to_cnt_q == TO_LAST);
  assign capture_data = bus_we ? 32'h0 : bus_rdata;

  assign rsp_rdata = rdata_q;
  assign rsp_err   = (state_q == S_DONE) && err_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_we, cmd_adr, cmd_wdata, cmd_wstrb};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req       = 1'b0;
    bus_valid = 1'b0;
    finish    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        req = 1'b1;
        if (gnt) begin
          state_d  = S_ADDR;
          to_cnt_d = '0;
        end
      end
      S_ADDR: begin
        bus_valid = sel;
        to_cnt_d  = to_cnt_q + TO_ONE;
        // A completion beats a timeout that lands on the same cycle.
        if (sel && bus_ready && bus_rvalid) begin
          rdata_d = capture_data;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (timed_out) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (sel && bus_ready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        to_cnt_d = to_cnt_q + TO_ONE;
        if (bus_rvalid) begin
          rdata_d = capture_data;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (timed_out) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        finish    = 1'b1;
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      to_cnt_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      to_cnt_q <= to_cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tbus_master_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tbus_master_port                                          |
// | Description : Directed self-checking bench for tbus_master_port.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tbus_master_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req, gnt, sel, finish;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [31:0] bus_adr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tbus_master_port #(
    .ADR_W (32),
    .DEPTH (2),
    .TO_CYC(8),
    .TO_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .finish    (finish),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_we    (bus_we),
    .bus_adr   (bus_adr),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .bus_rvalid(bus_rvalid),
    .bus_rdata (bus_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    settle();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    total++; if (req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", req); end
    total++; if (finish !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_finish_rsp: got %b%b want 00", finish, rsp_valid); end
    total++; if (bus_valid !== 1'b0 || rsp_err !== 1'b0) begin bad++; $display("FAIL rst_bus_valid_err: got %b%b want 00", bus_valid, rsp_err); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    total++; if (bus_adr !== 32'h0 || bus_we !== 1'b0) begin bad++; $display("FAIL rst_bus_fields: got %h/%b want 0/0", bus_adr, bus_we); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h100;
    tick();
    cmd_valid = 1'b0;
    settle();
    total++; if (req !== 1'b0) begin bad++; $display("FAIL t1_idle_req: got %b want 0", req); end
    tick();
    gnt = 1'b1;
    settle();
    total++; if (req !== 1'b1 || bus_valid !== 1'b0) begin bad++; $display("FAIL t1_req: got req=%b bv=%b want 1/0", req, bus_valid); end
    tick();
    gnt = 1'b0; sel = 1'b1; bus_ready = 1'b1;
    settle();
    total++; if (req !== 1'b0 || bus_valid !== 1'b1) begin bad++; $display("FAIL t1_addr: got req=%b bv=%b want 0/1", req, bus_valid); end
    total++; if (bus_adr !== 32'h100 || bus_we !== 1'b0) begin bad++; $display("FAIL t1_bus_adr: got %h/%b want 100/0", bus_adr, bus_we); end
    tick();
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
    settle();
    total++; if (bus_valid !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL t1_resp: got bv=%b rv=%b want 0/0", bus_valid, rsp_valid); end
    tick();
    bus_rvalid = 1'b0; sel = 1'b0;
    settle();
    total++; if (rsp_valid !== 1'b1 || finish !== 1'b1 || req !== 1'b0) begin bad++; $display("FAIL t1_done: got rv=%b fin=%b req=%b want 1/1/0", rsp_valid, finish, req); end
    total++; if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin bad++; $display("FAIL t1_rdata: got %h err=%b want deadbeef/0", rsp_rdata, rsp_err); end
    tick();
    settle();
    total++; if (rsp_valid !== 1'b0 || finish !== 1'b0) begin bad++; $display("FAIL t1_after: got rv=%b fin=%b want 0/0", rsp_valid, finish); end
  endtask

  task automatic test_ignored();
    gnt = 1'b1; sel = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    tick();
    tick();
    settle();
    total++; if (req !== 1'b0 || bus_valid !== 1'b0) begin bad++; $display("FAIL ign_req_bv: got %b%b want 00", req, bus_valid); end
    total++; if (rsp_valid !== 1'b0 || finish !== 1'b0) begin bad++; $display("FAIL ign_rsp: got %b%b want 00", rsp_valid, finish); end
    total++; if (rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ign_rdata: got %h want deadbeef", rsp_rdata); end
    gnt = 1'b0; sel = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic test_delayed_grant();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h200; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'b0011;
    tick();
    cmd_valid = 1'b0;
    tick();
    sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      total++; if (req !== 1'b1 || bus_valid !== 1'b0) begin bad++; $display("FAIL t2_wait%0d: got req=%b bv=%b want 1/0", i, req, bus_valid); end
      tick();
    end
    gnt = 1'b1;
    settle();
    total++; if (req !== 1'b1) begin bad++; $display("FAIL t2_req6: got %b want 1", req); end
    tick();
    gnt = 1'b0; bus_ready = 1'b1;
    settle();
    total++; if (bus_valid !== 1'b1 || bus_we !== 1'b1 || bus_wstrb !== 4'b0011) begin bad++; $display("FAIL t2_beat: got bv=%b we=%b strb=%b want 1/1/0011", bus_valid, bus_we, bus_wstrb); end
    total++; if (bus_wdata !== 32'h55AA55AA || bus_adr !== 32'h200) begin bad++; $display("FAIL t2_data: got %h@%h want 55aa55aa@200", bus_wdata, bus_adr); end
    tick();
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    tick();
    bus_rvalid = 1'b0; sel = 1'b0;
    settle();
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin bad++; $display("FAIL t2_done: got rv=%b %h err=%b want 1/0/0", rsp_valid, rsp_rdata, rsp_err); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_adr [3];
    int last_fin;
    exp_adr[0] = 32'h300; exp_adr[1] = 32'h304; exp_adr[2] = 32'h308;
    last_fin = 0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h300;
    tick();
    cmd_adr = 32'h304;
    tick();
    cmd_adr = 32'h308;
    settle();
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL t3_full: got %b want 0", cmd_ready); end
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 20 && req !== 1'b1; w++) tick();
      total++; if (req !== 1'b1) begin bad++; $display("FAIL t3_req_wait%0d: got %b want 1", k, req); end
      gnt = 1'b1;
      tick();
      gnt = 1'b0; sel = 1'b1; bus_ready = 1'b1;
      settle();
      total++; if (bus_adr !== exp_adr[k]) begin bad++; $display("FAIL t3_order%0d: got %h want %h", k, bus_adr, exp_adr[k]); end
      if (k == 0) begin
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL t3_full_addr: got %b want 0", cmd_ready); end
      end
      tick();
      bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'(32'hA0 + k);
      tick();
      bus_rvalid = 1'b0; sel = 1'b0;
      settle();
      total++; if (rsp_valid !== 1'b1 || finish !== 1'b1 || rsp_rdata !== 32'(32'hA0 + k)) begin bad++; $display("FAIL t3_rsp%0d: got rv=%b fin=%b %h want 1/1/%h", k, rsp_valid, finish, rsp_rdata, 32'(32'hA0 + k)); end
      if (k == 0) begin
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL t3_push_in_done: got %b want 1", cmd_ready); end
      end else begin
        total++; if (cyc - last_fin < 3) begin bad++; $display("FAIL t3_gap%0d: got %0d want >=3", k, cyc - last_fin); end
      end
      last_fin = cyc;
      tick();
      cmd_valid = 1'b0;
    end
    tick();
    settle();
    total++; if (req !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL t3_drained: got req=%b rdy=%b want 0/1", req, cmd_ready); end
  endtask

  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h400;
    tick();
    cmd_valid = 1'b0;
    for (int w = 0; w < 20 && req !== 1'b1; w++) tick();
    total++; if (req !== 1'b1) begin bad++; $display("FAIL t4_req_wait: got %b want 1", req); end
    gnt = 1'b1;
    tick();
    gnt = 1'b0; sel = 1'b1; bus_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      settle();
      if (i < 8) begin
        total++; if (rsp_valid !== 1'b0 || finish !== 1'b0) begin bad++; $display("FAIL t4_early%0d: got rv=%b fin=%b want 0/0", i, rsp_valid, finish); end
      end else begin
        total++; if (rsp_valid !== 1'b1 || finish !== 1'b1 || rsp_err !== 1'b1) begin bad++; $display("FAIL t4_done: got rv=%b fin=%b err=%b want 1/1/1", rsp_valid, finish, rsp_err); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL t4_rdata: got %h want 0", rsp_rdata); end
      end
    end
    sel = 1'b0;
    tick();
    settle();
    total++; if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL t4_err_clear: got err=%b rv=%b want 0/0", rsp_err, rsp_valid); end
    tick();
    tick();
    settle();
    total++; if (req !== 1'b0) begin bad++; $display("FAIL t4_popped: got req=%b want 0", req); end
  endtask

  task automatic test_same_cycle();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h500;
    tick();
    cmd_valid = 1'b0;
    for (int w = 0; w < 20 && req !== 1'b1; w++) tick();
    total++; if (req !== 1'b1) begin bad++; $display("FAIL t5_req_wait: got %b want 1", req); end
    gnt = 1'b1;
    tick();
    gnt = 1'b0; sel = 1'b1; bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    tick();
    bus_ready = 1'b0; bus_rvalid = 1'b0; sel = 1'b0;
    settle();
    total++; if (rsp_valid !== 1'b1 || finish !== 1'b1 || rsp_err !== 1'b0) begin bad++; $display("FAIL t5_direct_done: got rv=%b fin=%b err=%b want 1/1/0", rsp_valid, finish, rsp_err); end
    total++; if (rsp_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL t5_rdata: got %h want cafef00d", rsp_rdata); end
    tick();
    settle();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL t5_single_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h600;
    tick();
    cmd_valid = 1'b0;
    for (int w = 0; w < 20 && req !== 1'b1; w++) tick();
    total++; if (req !== 1'b1) begin bad++; $display("FAIL t6_req_wait: got %b want 1", req); end
    gnt = 1'b1;
    tick();
    gnt = 1'b0; sel = 1'b1; bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0; rst_n = 1'b0;
    tick();
    settle();
    total++; if (req !== 1'b0 || finish !== 1'b0 || rsp_valid !== 1'b0 || bus_valid !== 1'b0) begin bad++; $display("FAIL t6_rst_outs: got req=%b fin=%b rv=%b bv=%b want 0000", req, finish, rsp_valid, bus_valid); end
    total++; if (cmd_ready !== 1'b1 || rsp_rdata !== 32'h0 || bus_adr !== 32'h0) begin bad++; $display("FAIL t6_rst_state: got rdy=%b %h adr=%h want 1/0/0", cmd_ready, rsp_rdata, bus_adr); end
    rst_n = 1'b1; sel = 1'b0;
    tick();
    tick();
    settle();
    total++; if (req !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL t6_silent: got req=%b rv=%b want 0/0", req, rsp_valid); end
    cmd_valid = 1'b1; cmd_adr = 32'h700;
    tick();
    cmd_valid = 1'b0;
    for (int w = 0; w < 20 && req !== 1'b1; w++) tick();
    total++; if (req !== 1'b1) begin bad++; $display("FAIL t6_req_wait2: got %b want 1", req); end
    gnt = 1'b1;
    tick();
    gnt = 1'b0; sel = 1'b1; bus_ready = 1'b1;
    settle();
    total++; if (bus_adr !== 32'h700) begin bad++; $display("FAIL t6_new_adr: got %h want 700", bus_adr); end
    tick();
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h77;
    tick();
    bus_rvalid = 1'b0; sel = 1'b0;
    settle();
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h77 || finish !== 1'b1) begin bad++; $display("FAIL t6_new_rsp: got rv=%b %h fin=%b want 1/77/1", rsp_valid, rsp_rdata, finish); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    gnt = 1'b0; sel = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    test_reset();
    test_single_read();
    test_ignored();
    test_delayed_grant();
    test_back_to_back();
    test_timeout();
    test_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
